// File: rtl/mpsoc_dbg_crc_seq.sv
// Burst CRC sequencer: steers the serial CRC32 engine through the data and CRC phases
// of a debug burst. It checks the host CRC on writes and shifts the engine CRC out on reads.
module mpsoc_dbg_crc_seq #(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             tdi,
  input  logic             rd_bit,
  input  logic             crc_serial,
  output logic             crc_clr,
  output logic             crc_enable,
  output logic             crc_shift,
  output logic             crc_data,
  output logic             tdo,
  output logic             word_done,
  output logic             busy,
  output logic             done,
  output logic             crc_ok
);

  localparam int unsigned     BIT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_STATUS,
    S_DONE
  } state_t;

  state_t           state;
  logic             dir_q;
  logic [CNT_W-1:0] wcnt;
  logic [BIT_W-1:0] bitcnt;
  logic [4:0]       crccnt;
  logic             mismatch;
  logic             bit_err;
  logic             last_bit;

  always_comb begin
    bit_err    = tdi ^ crc_serial;
    last_bit   = (bitcnt == BIT_LAST);
    crc_clr    = 1'b0;
    crc_enable = 1'b0;
    crc_shift  = 1'b0;
    crc_data   = 1'b0;
    tdo        = 1'b0;
    word_done  = 1'b0;
    // abort suppresses every engine control in the cycle it is asserted
    if (!abort) begin
      unique case (state)
        S_IDLE:   crc_clr = start;
        S_DATA: begin
          crc_enable = bit_valid;
          crc_data   = dir_q ? rd_bit : tdi;
          tdo        = dir_q & rd_bit;
          word_done  = bit_valid & last_bit;
        end
        S_CRC: begin
          crc_shift = bit_valid;
          tdo       = dir_q & crc_serial;
        end
        S_STATUS: tdo = ~mismatch;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      dir_q    <= 1'b0;
      wcnt     <= '0;
      bitcnt   <= '0;
      crccnt   <= '0;
      mismatch <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      bitcnt   <= '0;
      crccnt   <= '0;
      mismatch <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dir_q    <= dir;
            wcnt     <= word_count;
            bitcnt   <= '0;
            crccnt   <= '0;
            mismatch <= 1'b0;
            crc_ok   <= 1'b0;
            busy     <= 1'b1;
            state    <= (word_count != '0) ? S_DATA : S_CRC;
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            if (last_bit) begin
              bitcnt <= '0;
              if (wcnt != '0) wcnt <= wcnt - 1'b1;
              if (wcnt <= CNT_W'(1)) state <= S_CRC;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (bit_valid) begin
            crccnt <= crccnt + 1'b1;
            if (!dir_q) mismatch <= mismatch | bit_err;
            if (crccnt == 5'd31) begin
              crccnt <= '0;
              if (dir_q) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                // include the 32nd bit's compare, which has not reached mismatch yet
                state  <= S_STATUS;
                crc_ok <= ~(mismatch | bit_err);
              end
            end
          end
        end
        S_STATUS: begin
          if (bit_valid) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
